// File: rtl/cv32e40p_register_file_scrubber.sv
// Background scrubber for the Hamming-protected register file.
// Sweeps x1..x(NUM_REGS-1) through an idle read port. Each correctable fault
// is written back as corrected data through an idle write port. A core write
// to the same register always wins over the scrubber's copy.
module cv32e40p_register_file_scrubber #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned INTERVAL   = 1024,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    output logic                  rreq_o,
    input  logic                  rgnt_i,
    output logic [ADDR_WIDTH-1:0] raddr_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  fault_i,
    output logic                  wreq_o,
    input  logic                  wgnt_i,
    output logic [ADDR_WIDTH-1:0] waddr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    input  logic                  core_we_i,
    input  logic [ADDR_WIDTH-1:0] core_waddr_i,
    output logic                  busy_o,
    output logic                  sweep_done_o,
    output logic [CNT_WIDTH-1:0]  err_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_WB   = 2'd2,
        S_ADV  = 2'd3
    } state_e;

    localparam int unsigned TIMER_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(INTERVAL - 1);
    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = '1;

    state_e                  state_q, state_d;
    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    core_hit;

    // The core is overwriting the register currently being scrubbed.
    assign core_hit = core_we_i && (core_waddr_i == addr_q);

    // State register: all scrubber state, synchronously reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            addr_q  <= FIRST_ADDR;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: interval timer, sweep sequencing and writeback decisions.
    always_comb begin
        // NOTE: hold-value defaults first so no path leaves a variable unassigned (no latches).
        state_d = state_q;
        timer_d = timer_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (!enable_i) begin
                    timer_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    addr_d  = FIRST_ADDR;
                    state_d = S_READ;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            S_READ: begin
                if (rgnt_i) begin
                    // A same-cycle core write makes the faulty word stale anyway.
                    if (fault_i && !core_hit) begin
                        data_d  = rdata_i;
                        state_d = S_WB;
                    end else begin
                        state_d = S_ADV;
                    end
                end else if (!enable_i) begin
                    addr_d  = FIRST_ADDR;
                    state_d = S_IDLE;
                end
            end
            S_WB: begin
                // Core data is newer than our corrected copy: drop the writeback.
                if (core_hit) begin
                    state_d = S_ADV;
                end else if (wgnt_i) begin
                    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                    state_d = S_ADV;
                end
            end
            S_ADV: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = FIRST_ADDR;
                    timer_d = '0;
                    state_d = S_IDLE;
                end else begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = enable_i ? S_READ : S_IDLE;
                end
            end
            default: begin
                addr_d  = FIRST_ADDR;
                timer_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: registered-state decodes; the write request is also held off during reset.
    always_comb begin
        rreq_o       = (state_q == S_READ);
        raddr_o      = (state_q == S_READ) ? addr_q : '0;
        wreq_o       = (state_q == S_WB) && !rst;
        waddr_o      = (state_q == S_WB) ? addr_q : '0;
        wdata_o      = (state_q == S_WB) ? data_q : '0;
        busy_o       = (state_q != S_IDLE);
        sweep_done_o = (state_q == S_ADV) && (addr_q == LAST_ADDR);
        err_cnt_o    = cnt_q;
    end

endmodule

// File: tb/tb_cv32e40p_register_file_scrubber.sv
// Self-checking bench for the register file scrubber: directed scenarios
// followed by a randomized run scored against a transaction-level model.
module tb_cv32e40p_register_file_scrubber;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int IV = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable_i;
    logic          rreq_o;
    logic          rgnt_i;
    logic [AW-1:0] raddr_o;
    logic [DW-1:0] rdata_i;
    logic          fault_i;
    logic          wreq_o;
    logic          wgnt_i;
    logic [AW-1:0] waddr_o;
    logic [DW-1:0] wdata_o;
    logic          core_we_i;
    logic [AW-1:0] core_waddr_i;
    logic          busy_o;
    logic          sweep_done_o;
    logic [CW-1:0] err_cnt_o;

    cv32e40p_register_file_scrubber #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .INTERVAL   (IV),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable_i),
        .rreq_o       (rreq_o),
        .rgnt_i       (rgnt_i),
        .raddr_o      (raddr_o),
        .rdata_i      (rdata_i),
        .fault_i      (fault_i),
        .wreq_o       (wreq_o),
        .wgnt_i       (wgnt_i),
        .waddr_o      (waddr_o),
        .wdata_o      (wdata_o),
        .core_we_i    (core_we_i),
        .core_waddr_i (core_waddr_i),
        .busy_o       (busy_o),
        .sweep_done_o (sweep_done_o),
        .err_cnt_o    (err_cnt_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Register-file decoder stand-in for the directed scenarios.
    logic          fault_map [64];
    logic [DW-1:0] data_map  [64];
    bit            rand_mode = 1'b0;

    // Per-sweep observations.
    int            busy_cnt, done_cnt, wr_cnt, wreq_cnt;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr [$];
    int            rd_idx  [$];

    // Random-phase reference model.
    int            exp_addr, sweeps_exp, done_seen;
    bit            pend_v;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_data;
    int            cnt_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rand_mode) begin
            fault_i = rreq_o && fault_map[raddr_o];
            rdata_i = data_map[raddr_o];
        end
        #1;
    endtask

    task automatic clear_map();
        for (int i = 0; i < 64; i++) begin
            fault_map[i] = 1'b0;
            data_map[i]  = '0;
        end
    endtask

    // Observe one sweep from start until the scrubber returns to idle.
    task automatic run_sweep(input string tag, input int max_cycles);
        bit started = 1'b0;
        bit timeout = 1'b1;
        busy_cnt = 0; done_cnt = 0; wr_cnt = 0; wreq_cnt = 0;
        wr_addr = '0; wr_data = '0;
        rd_addr.delete(); rd_idx.delete();
        for (int c = 0; c < max_cycles; c++) begin
            if (busy_o) begin
                started = 1'b1;
                busy_cnt++;
                if (rreq_o) begin
                    rd_addr.push_back(raddr_o);
                    rd_idx.push_back(c);
                end
                if (wreq_o) wreq_cnt++;
                if (wreq_o && wgnt_i && !(core_we_i && core_waddr_i == waddr_o)) begin
                    wr_cnt++;
                    wr_addr = waddr_o;
                    wr_data = wdata_o;
                end
                if (sweep_done_o) done_cnt++;
            end else if (started) begin
                timeout = 1'b0;
                break;
            end
            tick();
        end
        check({tag, "_timeout"}, timeout, 1'b0);
    endtask

    task automatic wait_wreq(input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (wreq_o) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_wreq_timeout"}, seen, 1'b1);
    endtask

    task automatic idle_to_first_read(input string tag);
        tick(); tick(); tick();
        check({tag, "_no_early_rreq"}, rreq_o, 1'b0);
        tick();
        check({tag, "_rreq_rise"}, rreq_o, 1'b1);
        check({tag, "_first_raddr"}, raddr_o, 6'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            seq_ok, stall_ok;
        int            k5, k6, diff;
        bit            hit;

        clear_map();
        rst = 1'b1; enable_i = 1'b0; rgnt_i = 1'b0; wgnt_i = 1'b0;
        rdata_i = '0; fault_i = 1'b0; core_we_i = 1'b0; core_waddr_i = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("reset_outputs",
              {rreq_o, wreq_o, busy_o, sweep_done_o, raddr_o, waddr_o, wdata_o, err_cnt_o}, '0);

        // 1: fault-free sweep with constant grants.
        enable_i = 1'b1; rgnt_i = 1'b1;
        idle_to_first_read("t1");
        run_sweep("t1", 200);
        enable_i = 1'b0;
        seq_ok = (rd_addr.size() == NR - 1);
        foreach (rd_addr[i]) if (rd_addr[i] != AW'(i + 1)) seq_ok = 1'b0;
        check("t1_raddr_seq", seq_ok, 1'b1);
        check("t1_busy_cycles", busy_cnt, 2 * (NR - 1));
        check("t1_done_pulses", done_cnt, 1);
        check("t1_wreq_seen", wreq_cnt, 0);
        check("t1_err_cnt", err_cnt_o, 16'd0);
        tick();

        // 2: single correctable fault at x5.
        fault_map[5] = 1'b1; data_map[5] = 32'hDEADBEEF;
        wgnt_i = 1'b1; enable_i = 1'b1;
        run_sweep("t2", 300);
        enable_i = 1'b0;
        clear_map();
        check("t2_busy_cycles", busy_cnt, 2 * (NR - 1) + 1);
        check("t2_writes", wr_cnt, 1);
        check("t2_waddr", wr_addr, 6'd5);
        check("t2_wdata", wr_data, 32'hDEADBEEF);
        check("t2_err_cnt", err_cnt_o, 16'd1);
        k5 = -1; k6 = -1;
        foreach (rd_addr[i]) begin
            if (rd_addr[i] == 6'd5) k5 = rd_idx[i];
            if (rd_addr[i] == 6'd6) k6 = rd_idx[i];
        end
        diff = (k5 >= 0 && k6 >= 0) ? (k6 - k5) : -1;
        check("t2_x5_cycles", diff, 3);
        tick();

        // 3: writeback at x7 stalled, then overtaken by a core write.
        fault_map[7] = 1'b1; data_map[7] = 32'h12345678;
        wgnt_i = 1'b0; enable_i = 1'b1;
        wait_wreq("t3");
        check("t3_waddr", waddr_o, 6'd7);
        check("t3_wdata", wdata_o, 32'h12345678);
        tick(); tick();
        check("t3_wreq_held", wreq_o, 1'b1);
        tick();
        core_we_i = 1'b1; core_waddr_i = 6'd7;
        tick();
        core_we_i = 1'b0; core_waddr_i = '0;
        check("t3_wreq_dropped", {wreq_o, busy_o, rreq_o}, 3'b010);
        tick();
        check("t3_next_raddr", {rreq_o, raddr_o}, {1'b1, 6'd8});
        check("t3_err_cnt", err_cnt_o, 16'd1);
        clear_map();
        run_sweep("t3", 200);
        enable_i = 1'b0;
        check("t3_done", done_cnt, 1);
        check("t3_no_write", wr_cnt, 0);
        tick();

        // 4: read grant withheld at x3, then disable aborts the sweep.
        wgnt_i = 1'b1; rgnt_i = 1'b1; enable_i = 1'b1;
        seq_ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (rreq_o && raddr_o == 6'd3) begin
                seq_ok = 1'b1;
                break;
            end
            tick();
        end
        check("t4_reach_x3", seq_ok, 1'b1);
        rgnt_i = 1'b0;
        stall_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (!(rreq_o && raddr_o == 6'd3 && !wreq_o && !sweep_done_o)) stall_ok = 1'b0;
        end
        check("t4_stall_hold", stall_ok, 1'b1);
        enable_i = 1'b0;
        tick();
        check("t4_aborted", {busy_o, rreq_o, wreq_o, sweep_done_o}, 4'b0000);
        tick();
        check("t4_still_idle", {busy_o, sweep_done_o}, 2'b00);
        rgnt_i = 1'b1; enable_i = 1'b1;
        idle_to_first_read("t4");
        run_sweep("t4", 200);
        enable_i = 1'b0;
        check("t4_done", done_cnt, 1);
        check("t4_err_cnt", err_cnt_o, 16'd1);
        tick();

        // 5: counter saturates at all-ones.
        force dut.cnt_q = 16'hFFFF;
        tick();
        release dut.cnt_q;
        tick();
        check("t5_preload", err_cnt_o, 16'hFFFF);
        fault_map[2] = 1'b1; data_map[2] = 32'h0BADF00D;
        wgnt_i = 1'b1; enable_i = 1'b1;
        run_sweep("t5", 300);
        enable_i = 1'b0;
        clear_map();
        check("t5_writes", wr_cnt, 1);
        check("t5_waddr", wr_addr, 6'd2);
        check("t5_err_sat", err_cnt_o, 16'hFFFF);
        tick();

        // 6: reset during a granted writeback.
        fault_map[4] = 1'b1; data_map[4] = 32'hA5A55A5A;
        wgnt_i = 1'b0; enable_i = 1'b1;
        wait_wreq("t6");
        check("t6_waddr", waddr_o, 6'd4);
        wgnt_i = 1'b1; rst = 1'b1;
        #1;
        check("t6_no_write_in_reset", wreq_o, 1'b0);
        tick();
        rst = 1'b0;
        clear_map();
        check("t6_outputs_cleared",
              {rreq_o, wreq_o, busy_o, sweep_done_o, raddr_o, waddr_o, wdata_o, err_cnt_o}, '0);
        idle_to_first_read("t6");
        enable_i = 1'b0;
        run_sweep("t6", 200);
        tick();

        // 7: randomized traffic against the transaction-level model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rand_mode = 1'b1;
        enable_i = 1'b1;
        exp_addr = 1; sweeps_exp = 0; done_seen = 0; pend_v = 1'b0; cnt_m = 0;
        pend_addr = '0; pend_data = '0;
        for (int i = 0; i < 3030; i++) begin
            if (i < 3000) begin
                rgnt_i       = ($urandom_range(0, 9) < 7);
                wgnt_i       = 1'($urandom_range(0, 1));
                core_we_i    = ($urandom_range(0, 4) == 0);
                core_waddr_i = ($urandom_range(0, 1) == 1) ? (pend_v ? pend_addr : AW'(exp_addr))
                                                           : AW'($urandom_range(0, NR - 1));
                fault_i      = rreq_o && ($urandom_range(0, 3) == 0);
                rdata_i      = $urandom();
            end else begin
                enable_i = 1'b0; rgnt_i = 1'b1; wgnt_i = 1'b1;
                core_we_i = 1'b0; fault_i = 1'b0;
            end
            #1;
            check("rnd_wreq", wreq_o, pend_v);
            if (pend_v) begin
                check("rnd_waddr", waddr_o, pend_addr);
                check("rnd_wdata", wdata_o, pend_data);
                hit = core_we_i && (core_waddr_i == pend_addr);
                if (hit) begin
                    pend_v = 1'b0;
                end else if (wgnt_i) begin
                    if (cnt_m < 65535) cnt_m++;
                    pend_v = 1'b0;
                end
            end else if (rreq_o && rgnt_i) begin
                check("rnd_raddr", raddr_o, AW'(exp_addr));
                hit = core_we_i && (core_waddr_i == AW'(exp_addr));
                if (fault_i && !hit) begin
                    pend_v    = 1'b1;
                    pend_addr = AW'(exp_addr);
                    pend_data = rdata_i;
                end
                if (exp_addr == NR - 1) begin
                    sweeps_exp++;
                    exp_addr = 1;
                end else begin
                    exp_addr++;
                end
            end
            if (sweep_done_o) done_seen++;
            tick();
        end
        check("rnd_err_cnt", err_cnt_o, CW'(cnt_m));
        check("rnd_sweeps", done_seen, sweeps_exp);
        check("rnd_idle", busy_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
